// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;

   localparam int ADDR_W_DEF    = 6;
   localparam int DATA_W_DEF    = 32;
   localparam int MAX_BURST_DEF = 16;

   // Port indices: port 0 is the Wishbone side, port 1 the FIFO side.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Ownership state that corresponds to granting the given port.
   function automatic arb_state_e own_state(input logic port);
      return port ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/sram_arb_rd_tag.sv
// One-cycle read-return pipeline: remembers that a read beat was accepted
// and which port issued it, so the SRAM's registered data is steered back
// to that port even if ownership has already moved on.
module sram_arb_rd_tag
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rd_fire,
   input  logic       rd_owner,
   output logic [1:0] rs_valid
);

   logic pend;
   logic tag;

   // Capture the read fire and its owner for exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= 1'b0;
         tag  <= PORT0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         pend <= rd_fire;
         tag  <= rd_owner;
      end
   end

   // Decode the pending tag into a one-hot per-port valid.
   always_comb begin
      // NOTE: assigning a default first guarantees no latch is inferred.
      rs_valid = '0;
      if (pend) rs_valid[tag] = 1'b1;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port burst arbiter in front of a single-port SRAM with a
// one-cycle registered read. Ports alternate on ties; a grant is held until
// the owner's last beat or MAX_BURST beats, whichever comes first.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             rq_valid,
   input  logic [1:0][ADDR_W-1:0] rq_adr,
   input  logic [1:0]             rq_we,
   input  logic [1:0][DATA_W-1:0] rq_datwr,
   input  logic [1:0]             rq_last,
   output logic [1:0]             rq_ready,
   output logic [1:0]             rs_valid,
   output logic [DATA_W-1:0]      rs_datrd,
   output logic [ADDR_W-1:0]      sram_adr,
   output logic [DATA_W-1:0]      sram_dat_w,
   output logic                   sram_we,
   input  logic [DATA_W-1:0]      sram_dat_r
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e        state, state_nx;
   logic              last_srv, last_srv_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              arm;
   logic              owner;
   logic              accept;
   logic              rel;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;

   assign owner  = (state == OWN1);
   assign accept = |(rq_valid & rq_ready);
   assign rel    = accept & (rq_last[owner] | (cnt == CNT_W'(MAX_BURST - 1)));

   // SRAM request passes straight through on accept, otherwise holds.
   assign sram_adr   = accept ? rq_adr[owner]   : adr_q;
   assign sram_dat_w = accept ? rq_datwr[owner] : dat_q;
   assign sram_we    = accept & rq_we[owner];
   assign rs_datrd   = sram_dat_r;

   // Ready is a pure decode of the ownership state.
   always_comb begin
      rq_ready = '0;
      if (state == OWN0) rq_ready[PORT0] = 1'b1;
      if (state == OWN1) rq_ready[PORT1] = 1'b1;
   end

   // Next-state, last-served pointer and beat counter.
   always_comb begin
      state_nx    = state;
      last_srv_nx = last_srv;
      cnt_nx      = cnt;
      case (state)
         IDLE: begin
            // arm delays the first grant to the second edge after reset.
            if (arm) begin
               cnt_nx = '0;
               if (rq_valid == 2'b11)  state_nx = own_state(!last_srv);
               else if (rq_valid[0])   state_nx = OWN0;
               else if (rq_valid[1])   state_nx = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (accept) cnt_nx = cnt + CNT_W'(1);
            if (rel) begin
               last_srv_nx = owner;
               cnt_nx      = '0;
               state_nx    = rq_valid[!owner] ? own_state(!owner) : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Arbitration state, counter and held SRAM request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         last_srv <= PORT1;
         cnt      <= '0;
         arm      <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         state    <= state_nx;
         last_srv <= last_srv_nx;
         cnt      <= cnt_nx;
         arm      <= 1'b1;
         if (accept) begin
            adr_q <= rq_adr[owner];
            dat_q <= rq_datwr[owner];
         end
      end
   end

   sram_arb_rd_tag u_rd_tag (
      .clk      (clk),
      .reset    (reset),
      .rd_fire  (accept & ~rq_we[owner]),
      .rd_owner (owner),
      .rs_valid (rs_valid)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural registered-read SRAM.
module tb_sram_arbiter;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [1:0]             rq_valid, rq_we, rq_last;
   logic [1:0][ADDR_W-1:0] rq_adr;
   logic [1:0][DATA_W-1:0] rq_datwr;
   logic [1:0]             rq_ready, rs_valid;
   logic [DATA_W-1:0]      rs_datrd, sram_dat_w, sram_dat_r;
   logic [ADDR_W-1:0]      sram_adr;
   logic                   sram_we;
   logic [DATA_W-1:0]      mem [0:63];

   int errors = 0;
   int checks = 0;

   sram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .rq_valid   (rq_valid),
      .rq_adr     (rq_adr),
      .rq_we      (rq_we),
      .rq_datwr   (rq_datwr),
      .rq_last    (rq_last),
      .rq_ready   (rq_ready),
      .rs_valid   (rs_valid),
      .rs_datrd   (rs_datrd),
      .sram_adr   (sram_adr),
      .sram_dat_w (sram_dat_w),
      .sram_we    (sram_we),
      .sram_dat_r (sram_dat_r)
   );

   always #5 clk = ~clk;

   // SRAM model: one-cycle registered read; known contents at 5 and 7.
   always @(posedge clk) begin
      if (!reset) begin
         mem[5] <= 32'hDEADBEEF;
         mem[7] <= 32'h12345678;
      end else if (sram_we) begin
         mem[sram_adr] <= sram_dat_w;
      end
      sram_dat_r <= mem[sram_adr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rq_valid = '0;
      rq_we    = '0;
      rq_last  = '0;
      rq_adr   = '0;
      rq_datwr = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) next();
      reset = 1'b1;
   endtask

   initial begin
      // ---- reset values ----
      reset = 1'b0;
      idle_inputs();
      #2;
      check("rst ready", rq_ready, 2'b00);
      check("rst rs_valid", rs_valid, 2'b00);
      check("rst we", sram_we, 1'b0);
      check("rst adr", sram_adr, 6'd0);
      check("rst dat_w", sram_dat_w, 32'd0);

      // ---- port 0 write burst of 4, first grant on 2nd edge ----
      do_reset();
      rq_valid = 2'b01; rq_we = 2'b01; rq_adr[0] = 6'd0; rq_datwr[0] = 32'hA0;
      #1;
      check("s1 c0 ready", rq_ready, 2'b00);
      next();
      check("s1 c1 ready", rq_ready, 2'b00);
      for (int i = 0; i < 4; i++) begin
         next();
         rq_adr[0]   = ADDR_W'(i);
         rq_datwr[0] = 32'hA0 + 32'(i);
         rq_last[0]  = (i == 3);
         #1;
         check("s1 beat ready", rq_ready, 2'b01);
         check("s1 beat we", sram_we, 1'b1);
         check("s1 beat adr", sram_adr, 64'(i));
         check("s1 beat dat", sram_dat_w, 64'(32'hA0 + 32'(i)));
      end
      next();
      idle_inputs();
      #1;
      check("s1 idle ready", rq_ready, 2'b00);
      check("s1 idle we", sram_we, 1'b0);
      check("s1 hold adr", sram_adr, 6'd3);
      check("s1 hold dat", sram_dat_w, 32'hA3);
      check("s1 mem0", mem[0], 32'hA0);
      check("s1 mem3", mem[3], 32'hA3);

      // ---- both ports from reset: port 0 first, then port 1 read ----
      do_reset();
      rq_valid = 2'b11; rq_we = 2'b01; rq_last = 2'b10;
      rq_adr[0] = 6'd10; rq_datwr[0] = 32'h11110000;
      rq_adr[1] = 6'd5;
      #1;
      check("s2 c0 ready", rq_ready, 2'b00);
      next();
      check("s2 c1 ready", rq_ready, 2'b00);
      next();
      check("s2 c2 ready", rq_ready, 2'b01);
      check("s2 c2 adr", sram_adr, 6'd10);
      rq_adr[0] = 6'd11; rq_datwr[0] = 32'h11110001; rq_last[0] = 1'b1;
      #1;
      check("s2 c3 ready", rq_ready, 2'b01);
      check("s2 c3 we", sram_we, 1'b1);
      next();
      rq_valid[0] = 1'b0;
      #1;
      check("s2 c4 ready", rq_ready, 2'b10);
      check("s2 c4 we", sram_we, 1'b0);
      check("s2 c4 adr", sram_adr, 6'd5);
      check("s2 c4 rs_valid", rs_valid, 2'b00);
      next();
      rq_valid = 2'b00;
      #1;
      check("s2 c5 rs_valid", rs_valid, 2'b10);
      check("s2 c5 rs_datrd", rs_datrd, 32'hDEADBEEF);
      check("s2 c5 ready", rq_ready, 2'b00);
      next();
      check("s2 c6 rs_valid", rs_valid, 2'b00);

      // ---- forced release at 16 beats, read on final beat ----
      do_reset();
      rq_valid = 2'b11; rq_we = 2'b01; rq_last = 2'b10;
      rq_adr[1] = 6'd7;
      #1;
      next();
      for (int b = 1; b <= 16; b++) begin
         next();
         rq_we[0]    = (b != 16);
         rq_adr[0]   = (b == 16) ? 6'd5 : ADDR_W'(16 + b);
         rq_datwr[0] = 32'hB000 + 32'(b);
         #1;
         check("s3 beat ready", rq_ready, 2'b01);
         check("s3 beat we", sram_we, 64'(b != 16));
      end
      next();
      rq_we[0] = 1'b1; rq_adr[0] = 6'd40; rq_datwr[0] = 32'hC0;
      #1;
      check("s3 sw ready", rq_ready, 2'b10);
      check("s3 sw rs_valid", rs_valid, 2'b01);
      check("s3 sw rs_datrd", rs_datrd, 32'hDEADBEEF);
      check("s3 sw adr", sram_adr, 6'd7);
      check("s3 sw we", sram_we, 1'b0);
      next();
      rq_valid[1] = 1'b0;
      #1;
      check("s3 regrant ready", rq_ready, 2'b01);
      check("s3 regrant rs_valid", rs_valid, 2'b10);
      check("s3 regrant rs_datrd", rs_datrd, 32'h12345678);
      check("s3 regrant we", sram_we, 1'b1);
      check("s3 regrant adr", sram_adr, 6'd40);
      next();
      rq_valid = 2'b10;
      #1;
      check("s3 hold ready", rq_ready, 2'b01);
      check("s3 hold we", sram_we, 1'b0);
      check("s3 hold adr", sram_adr, 6'd40);
      check("s3 hold dat", sram_dat_w, 32'hC0);
      next();
      check("s3 hold2 ready", rq_ready, 2'b01);

      // ---- reset during beat 2 of a read burst ----
      do_reset();
      rq_valid = 2'b01; rq_adr[0] = 6'd5;
      #1;
      next();
      next();
      check("s4 c2 ready", rq_ready, 2'b01);
      check("s4 c2 rs_valid", rs_valid, 2'b00);
      next();
      rq_adr[0] = 6'd7;
      #1;
      check("s4 c3 ready", rq_ready, 2'b01);
      check("s4 c3 rs_valid", rs_valid, 2'b01);
      check("s4 c3 rs_datrd", rs_datrd, 32'hDEADBEEF);
      reset = 1'b0;
      #1;
      check("s4 rst ready", rq_ready, 2'b00);
      check("s4 rst rs_valid", rs_valid, 2'b00);
      check("s4 rst we", sram_we, 1'b0);
      check("s4 rst adr", sram_adr, 6'd0);
      check("s4 rst dat_w", sram_dat_w, 32'd0);
      idle_inputs();
      next();
      next();
      reset = 1'b1;
      #1;
      check("s4 post rs_valid", rs_valid, 2'b00);
      check("s4 post ready", rq_ready, 2'b00);
      next();
      check("s4 post2 rs_valid", rs_valid, 2'b00);
      check("s4 post2 ready", rq_ready, 2'b00);
      check("s4 post2 adr", sram_adr, 6'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
